// File: rtl/alu_exec_unit.sv
// Registered 32-bit execute stage: operand-B select, ripple-carry add/sub core,
// ALU operation decode, and output flops for result, zero flag and carry.
module alu_exec_unit (
    input  logic        CLK,
    input  logic        RST,
    input  logic        EN,
    input  logic [31:0] A,
    input  logic [31:0] B_REG,
    input  logic [31:0] B_IMM,
    input  logic        B_SEL,
    input  logic [5:0]  OPRN,
    output logic [31:0] Y,
    output logic        ZERO,
    output logic        CO
);

    localparam logic [5:0] OP_ADD = 6'h01;
    localparam logic [5:0] OP_SUB = 6'h02;
    localparam logic [5:0] OP_MUL = 6'h03;
    localparam logic [5:0] OP_SRL = 6'h04;
    localparam logic [5:0] OP_SLL = 6'h05;
    localparam logic [5:0] OP_AND = 6'h06;
    localparam logic [5:0] OP_OR  = 6'h07;
    localparam logic [5:0] OP_NOR = 6'h08;
    localparam logic [5:0] OP_SLT = 6'h09;

    logic [31:0] b_op;
    logic        sna;
    logic [31:0] b_inv;
    logic [32:0] carry;
    logic [31:0] sum;
    logic        shamt_big;
    logic        ovf;

    logic [31:0] y_d, y_q;
    logic        zero_d, zero_q;
    logic        co_d, co_q;

    assign b_op = B_SEL ? B_REG : B_IMM;

    // Every op other than ADD drives the core as a subtractor so SLT can use it.
    assign sna      = (OPRN != OP_ADD);
    assign b_inv    = b_op ^ {32{sna}};
    assign carry[0] = sna;

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_rca
            assign sum[gi]      = A[gi] ^ b_inv[gi] ^ carry[gi];
            assign carry[gi+1]  = (A[gi] & b_inv[gi]) | (carry[gi] & (A[gi] ^ b_inv[gi]));
        end
    endgenerate

    assign shamt_big = |b_op[31:5];
    // Signed overflow of A-B: operand signs differ and result sign differs from A.
    assign ovf       = (A[31] ^ b_op[31]) & (A[31] ^ sum[31]);

    always_comb begin
        y_d  = 32'd0;
        co_d = 1'b0;
        unique case (OPRN)
            OP_ADD: begin
                y_d  = sum;
                co_d = carry[32];
            end
            OP_SUB: begin
                y_d  = sum;
                co_d = carry[32];
            end
            OP_MUL:  y_d = A * b_op;
            OP_SRL:  y_d = shamt_big ? 32'd0 : (A >> b_op[4:0]);
            OP_SLL:  y_d = shamt_big ? 32'd0 : (A << b_op[4:0]);
            OP_AND:  y_d = A & b_op;
            OP_OR:   y_d = A | b_op;
            OP_NOR:  y_d = ~(A | b_op);
            OP_SLT:  y_d = {31'd0, sum[31] ^ ovf};
            default: y_d = 32'd0;
        endcase
        zero_d = (y_d == 32'd0);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            y_q    <= 32'd0;
            zero_q <= 1'b1;
            co_q   <= 1'b0;
        end else if (EN) begin
            y_q    <= y_d;
            zero_q <= zero_d;
            co_q   <= co_d;
        end
    end

    assign Y    = y_q;
    assign ZERO = zero_q;
    assign CO   = co_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed plan cases plus randomized
// traffic compared against an arithmetic reference model.
module tb_alu_exec_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        EN;
    logic [31:0] A;
    logic [31:0] B_REG;
    logic [31:0] B_IMM;
    logic        B_SEL;
    logic [5:0]  OPRN;
    logic [31:0] Y;
    logic        ZERO;
    logic        CO;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_y;
    logic        m_z;
    logic        m_c;

    alu_exec_unit dut (
        .CLK   (CLK),
        .RST   (RST),
        .EN    (EN),
        .A     (A),
        .B_REG (B_REG),
        .B_IMM (B_IMM),
        .B_SEL (B_SEL),
        .OPRN  (OPRN),
        .Y     (Y),
        .ZERO  (ZERO),
        .CO    (CO)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Returns {carry, result} computed directly from the operation definitions.
    function automatic logic [32:0] ref_alu(input logic [5:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [32:0] s;
        case (op)
            6'h01: begin
                s = {1'b0, a} + {1'b0, b};
                return s;
            end
            6'h02: return {(a >= b), a - b};
            6'h03: return {1'b0, a * b};
            6'h04: return {1'b0, (b >= 32) ? 32'd0 : a >> b};
            6'h05: return {1'b0, (b >= 32) ? 32'd0 : a << b};
            6'h06: return {1'b0, a & b};
            6'h07: return {1'b0, a | b};
            6'h08: return {1'b0, ~(a | b)};
            6'h09: return {1'b0, 31'd0, ($signed(a) < $signed(b))};
            default: return 33'd0;
        endcase
    endfunction

    task automatic step(input logic rst, input logic en, input logic [31:0] a,
                        input logic [31:0] breg, input logic [31:0] bimm,
                        input logic bsel, input logic [5:0] op, input string tag);
        logic [32:0] r;
        RST = rst; EN = en; A = a; B_REG = breg; B_IMM = bimm; B_SEL = bsel; OPRN = op;
        r = ref_alu(op, a, bsel ? breg : bimm);
        @(posedge CLK);
        #1;
        if (rst) begin
            m_y = 32'd0; m_z = 1'b1; m_c = 1'b0;
        end else if (en) begin
            m_y = r[31:0]; m_z = (r[31:0] == 32'd0); m_c = r[32];
        end
        $display("%s rst=%0b en=%0b op=%02h a=%08h b=%08h -> Y=%08h Z=%0b C=%0b",
                 tag, rst, en, op, a, bsel ? breg : bimm, Y, ZERO, CO);
        chk({tag, "_y"}, Y, m_y);
        chk({tag, "_zero"}, {31'd0, ZERO}, {31'd0, m_z});
        chk({tag, "_co"}, {31'd0, CO}, {31'd0, m_c});
    endtask

    // Directed case: model check plus a literal expectation for the result.
    task automatic dstep(input logic [31:0] a, input logic [31:0] breg, input logic [31:0] bimm,
                         input logic bsel, input logic [5:0] op, input string tag,
                         input logic [31:0] exp_y);
        step(1'b0, 1'b1, a, breg, bimm, bsel, op, tag);
        chk({tag, "_lit"}, Y, exp_y);
    endtask

    initial begin
        m_y = 32'd0; m_z = 1'b1; m_c = 1'b0;

        step(1'b1, 1'b1, 32'd5, 32'd7, 32'd0, 1'b1, 6'h01, "rst0");
        chk("rst0_lit_y", Y, 32'd0);
        chk("rst0_lit_z", {31'd0, ZERO}, 32'd1);
        step(1'b1, 1'b1, 32'd5, 32'd7, 32'd0, 1'b1, 6'h01, "rst1");
        dstep(32'd5, 32'd7, 32'd0, 1'b1, 6'h01, "rel", 32'd12);

        dstep(32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 6'h01, "add_wrap", 32'd0);
        chk("add_wrap_co", {31'd0, CO}, 32'd1);
        dstep(32'd3, 32'd5, 32'd0, 1'b1, 6'h02, "sub_borrow", 32'hFFFF_FFFE);
        chk("sub_borrow_co", {31'd0, CO}, 32'd0);
        dstep(32'd5, 32'd5, 32'd0, 1'b1, 6'h02, "sub_eq", 32'd0);
        chk("sub_eq_co", {31'd0, CO}, 32'd1);

        dstep(32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0000_00FF, 1'b1, 6'h06, "and_reg", 32'h00F0_00F0);
        dstep(32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0000_00FF, 1'b0, 6'h06, "and_imm", 32'h0000_00F0);
        dstep(32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0000_00FF, 1'b1, 6'h07, "or_reg", 32'hFFF0_FFF0);
        dstep(32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0000_00FF, 1'b1, 6'h08, "nor_reg", 32'h000F_000F);

        dstep(32'd1, 32'd0, 32'd31, 1'b0, 6'h05, "sll31", 32'h8000_0000);
        dstep(32'h8000_0000, 32'd0, 32'd4, 1'b0, 6'h04, "srl4", 32'h0800_0000);
        dstep(32'd1, 32'd0, 32'd32, 1'b0, 6'h05, "sll32", 32'd0);
        dstep(32'h8000_0000, 32'd0, 32'd33, 1'b0, 6'h04, "srl33", 32'd0);
        dstep(32'h0001_0000, 32'h0001_0001, 32'd0, 1'b1, 6'h03, "mul", 32'h0001_0000);

        dstep(32'h8000_0000, 32'h7FFF_FFFF, 32'd0, 1'b1, 6'h09, "slt_min", 32'd1);
        dstep(32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 1'b1, 6'h09, "slt_max", 32'd0);
        dstep(32'hFFFF_FFFF, 32'd0, 32'd0, 1'b1, 6'h09, "slt_neg", 32'd1);
        dstep(32'h1234_5678, 32'h1234_5678, 32'd0, 1'b1, 6'h09, "slt_eq", 32'd0);

        dstep(32'd5, 32'd7, 32'd0, 1'b1, 6'h01, "load12", 32'd12);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, $urandom, $urandom, $urandom, 1'($urandom), 6'h02, "hold");
            chk("hold_lit", Y, 32'd12);
        end
        dstep(32'd9, 32'd4, 32'd0, 1'b1, 6'h3F, "illegal", 32'd0);

        for (int i = 0; i < 400; i++) begin
            logic [5:0]  op;
            logic [31:0] a, br, bi;
            int          sel;
            sel = $urandom_range(0, 11);
            op  = (sel == 10) ? 6'h3F : (sel == 11) ? 6'h00 : 6'(sel);
            a   = $urandom;
            br  = $urandom;
            bi  = $urandom;
            if ($urandom_range(0, 3) == 0) br = 32'($urandom_range(0, 40));
            if ($urandom_range(0, 3) == 0) bi = 32'($urandom_range(0, 40));
            if ($urandom_range(0, 7) == 0) br = a;
            step(($urandom_range(0, 29) == 0), ($urandom_range(0, 4) != 0), a, br, bi,
                 1'($urandom), op, "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
